// File: rtl/mem_access_pkg.sv
// Shared constants, FSM states and request legality check for the load/store unit.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } state_t;

    // High when the request is an illegal funct3 for its direction or misaligned.
    function automatic logic access_error(input logic is_store, input logic [2:0] funct3,
                                          input logic [1:0] offset);
        logic legal;
        logic aligned;
        legal   = 1'b1;
        aligned = 1'b1;
        case (funct3)
            F3_B:    ;
            F3_H:    aligned = ~offset[0];
            F3_W:    aligned = (offset == 2'b00);
            F3_BU:   legal = ~is_store;
            F3_HU: begin
                legal   = ~is_store;
                aligned = ~offset[0];
            end
            default: legal = 1'b0;
        endcase
        return !(legal && aligned);
    endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Byte-lane logic: load extract/extend and sub-word store merge into a 32-bit word.
module lsu_byte_lane
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] new_data,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_data = word;
            F3_BU:   load_data = {24'h000000, byte_sel};
            F3_HU:   load_data = {16'h0000, half_sel};
            default: load_data = '0;
        endcase

        store_data = word;
        case (funct3)
            F3_B:    store_data[{offset, 3'b000} +: 8]   = new_data[7:0];
            F3_H:    store_data[{offset[1], 4'b0000} +: 16] = new_data[15:0];
            F3_W:    store_data = new_data;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: one request per handshake, sub-word stores done as read-modify-write.
module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    state_t      state, state_next;
    logic        write_q;
    logic        err_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q, data_q, rdata_q;
    logic        req_err;
    logic [31:0] lane_word, load_data, store_data;

    assign req_err = access_error(req_write, req_funct3, req_addr[1:0]);

    // One lane unit serves both paths: extract from live read data in RD, merge into data_q in WR.
    assign lane_word = (state == ST_RD) ? mem_read_data : data_q;

    lsu_byte_lane u_lane (
        .word       (lane_word),
        .new_data   (wdata_q),
        .funct3     (funct3_q),
        .offset     (addr_q[1:0]),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: if (req_valid) begin
                    write_q  <= req_write;
                    funct3_q <= req_funct3;
                    addr_q   <= req_addr;
                    wdata_q  <= req_wdata;
                    err_q    <= req_err;
                    if (req_err) rdata_q <= '0;
                end
                ST_RD: begin
                    data_q <= mem_read_data;
                    if (!write_q) rdata_q <= load_data;
                end
                ST_WR:   rdata_q <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req_valid) begin
                if (req_err)                              state_next = ST_RESP;
                else if (req_write && req_funct3 == F3_W) state_next = ST_WR;
                else                                      state_next = ST_RD;
            end
            ST_RD:   state_next = write_q ? ST_WR : ST_RESP;
            ST_WR:   state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign req_ready      = (state == ST_IDLE);
    assign resp_valid     = (state == ST_RESP);
    assign resp_error     = (state == ST_RESP) && err_q;
    assign resp_rdata     = rdata_q;
    assign mem_address    = {addr_q[31:2], 2'b00};
    assign mem_write      = (state == ST_WR) && !reset;
    assign mem_write_data = mem_write ? store_data : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized checks of mem_access_unit against a byte-addressed memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic [31:0] mem_read_data;

    logic [31:0] dmem [0:63];
    logic        load_en = 1'b0;
    logic [5:0]  load_idx = '0;
    logic [31:0] load_val = '0;
    logic [7:0]  rmem [0:255];

    int compares = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_error     (resp_error),
        .resp_rdata     (resp_rdata),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = dmem[mem_address[7:2]];

    always @(posedge clk) begin
        if (load_en) dmem[load_idx] <= load_val;
        else if (mem_write) dmem[mem_address[7:2]] <= mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte-granular little-endian memory, applied per access semantics.
    task automatic model(input logic w, input logic [2:0] f3, input int a, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd, output logic [31:0] wword,
                         output int lat, output int wcyc);
        int  nb;
        int  base;
        logic legal;
        nb    = 1 << f3[1:0];
        legal = w ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
        err   = !legal || (a % nb != 0);
        rd    = '0;
        wword = '0;
        wcyc  = 0;
        if (err) begin
            lat = 1;
        end else if (!w) begin
            lat = 2;
            for (int i = 0; i < nb; i++) rd[8*i +: 8] = rmem[a + i];
            if (!f3[2] && nb < 4 && rd[8*nb-1]) rd = rd | ~((32'h1 << (8*nb)) - 32'h1);
        end else begin
            lat  = (nb == 4) ? 2 : 3;
            wcyc = (nb == 4) ? 1 : 2;
            for (int i = 0; i < nb; i++) rmem[a + i] = wd[8*i +: 8];
            base = a - (a % 4);
            for (int i = 0; i < 4; i++) wword[8*i +: 8] = rmem[base + i];
        end
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input string tag);
        @(negedge clk);
        check({tag, ".ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
    endtask

    // Watches cycles 1..8 after acceptance; caller has already passed the acceptance edge.
    task automatic collect(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input string tag, output logic [31:0] got_rd);
        logic        exp_err;
        logic [31:0] exp_rd, exp_wword;
        int          exp_lat, exp_wcyc;
        int          resp_cyc = 0, wr_cyc = 0, wr_cnt = 0;
        logic [31:0] got_wd = '0, got_wa = '0;
        logic        got_err = 1'b0;
        logic        ready_bad = 1'b0;
        got_rd = '0;
        model(w, f3, int'(a), wd, exp_err, exp_rd, exp_wword, exp_lat, exp_wcyc);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (req_ready) ready_bad = 1'b1;
            if (mem_write) begin
                wr_cnt++;
                wr_cyc = c;
                got_wd = mem_write_data;
                got_wa = mem_address;
            end
            if (resp_valid) begin
                resp_cyc = c;
                got_err  = resp_error;
                got_rd   = resp_rdata;
                break;
            end
        end
        check({tag, ".resp_cycle"}, resp_cyc, exp_lat);
        check({tag, ".resp_error"}, {31'd0, got_err}, {31'd0, exp_err});
        check({tag, ".resp_rdata"}, got_rd, exp_rd);
        check({tag, ".ready_busy"}, {31'd0, ready_bad}, 32'd0);
        check({tag, ".write_count"}, wr_cnt, (exp_wcyc != 0) ? 1 : 0);
        if (exp_wcyc != 0) begin
            check({tag, ".write_cycle"}, wr_cyc, exp_wcyc);
            check({tag, ".write_data"}, got_wd, exp_wword);
            check({tag, ".write_addr"}, got_wa, a & 32'hFFFF_FFFC);
        end
    endtask

    task automatic run(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input string tag, output logic [31:0] got_rd);
        issue(w, f3, a, wd, tag);
        @(posedge clk);
        #1 req_valid = 1'b0;
        collect(w, f3, a, wd, tag, got_rd);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] v;

        // Preload both memory views while reset is held.
        for (int i = 0; i < 64; i++) begin
            v = (i == 16) ? 32'h8899_AABB : (i == 17) ? 32'h0 : $urandom;
            for (int b = 0; b < 4; b++) rmem[4*i + b] = v[8*b +: 8];
            load_en  = 1'b1;
            load_idx = i[5:0];
            load_val = v;
            @(posedge clk);
            #1;
        end
        load_en = 1'b0;

        @(negedge clk);
        check("rst.req_ready", {31'd0, req_ready}, 32'd1);
        check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst.resp_error", {31'd0, resp_error}, 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.mem_write", {31'd0, mem_write}, 32'd0);
        check("rst.mem_address", mem_address, 32'd0);
        check("rst.mem_write_data", mem_write_data, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        run(1'b0, 3'b000, 32'h41, 32'h0, "lb_41", rd);
        check("lb_41.plan", rd, 32'hFFFF_FFAA);
        @(negedge clk);
        check("lb_41.hold_rdata", resp_rdata, 32'hFFFF_FFAA);
        check("lb_41.valid_drop", {31'd0, resp_valid}, 32'd0);

        run(1'b0, 3'b101, 32'h42, 32'h0, "lhu_42", rd);
        check("lhu_42.plan", rd, 32'h0000_8899);
        run(1'b0, 3'b001, 32'h42, 32'h0, "lh_42", rd);
        check("lh_42.plan", rd, 32'hFFFF_8899);
        run(1'b1, 3'b000, 32'h43, 32'h1234_56CC, "sb_43", rd);
        run(1'b0, 3'b010, 32'h40, 32'h0, "lw_40", rd);
        check("lw_40.plan", rd, 32'hCC99_AABB);

        // SW followed by a back-to-back LW held on the request port.
        issue(1'b1, 3'b010, 32'h44, 32'hDEAD_BEEF, "sw_44");
        @(posedge clk);
        #1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h44;
        collect(1'b1, 3'b010, 32'h44, 32'hDEAD_BEEF, "sw_44", rd);
        @(negedge clk);
        check("b2b.ready_cycle3", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        collect(1'b0, 3'b010, 32'h44, 32'h0, "b2b_lw_44", rd);
        check("b2b_lw_44.plan", rd, 32'hDEAD_BEEF);

        run(1'b0, 3'b010, 32'h46, 32'h0, "lw_46_mis", rd);
        run(1'b1, 3'b001, 32'h41, 32'hFFFF_FFFF, "sh_41_mis", rd);
        run(1'b0, 3'b011, 32'h40, 32'h0, "ld_f3_011", rd);
        run(1'b1, 3'b011, 32'h40, 32'h5555_5555, "st_f3_011", rd);
        run(1'b1, 3'b100, 32'h40, 32'h5555_5555, "st_f3_100", rd);

        // SH at 0x40 with reset landing on the write cycle: the store must be dropped.
        issue(1'b1, 3'b001, 32'h40, 32'h0000_7777, "sh_rst");
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("sh_rst.no_write", {31'd0, mem_write}, 32'd0);
        check("sh_rst.no_wdata", mem_write_data, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("sh_rst.ready", {31'd0, req_ready}, 32'd1);
        check("sh_rst.no_resp", {31'd0, resp_valid}, 32'd0);
        check("sh_rst.rdata_clr", resp_rdata, 32'd0);
        run(1'b0, 3'b010, 32'h40, 32'h0, "sh_rst.lw_40", rd);
        check("sh_rst.lw_40.plan", rd, 32'hCC99_AABB);

        for (int n = 0; n < 150; n++) begin
            logic        w;
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] wd;
            w  = $urandom_range(0, 1) == 1;
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom_range(0, 255);
            wd = $urandom;
            run(w, f3, a, wd, $sformatf("rnd%0d", n), rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
